// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add multiplier: one WIDTH-bit ripple adder, WIDTH iterations,
// valid/ready handshakes on both the operand and the product side.

module ripple_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];
endmodule

// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | one add-and-shift per cycle, WIDTH cycles
// DONE  | product valid, held until out_ready
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;

  assign addend = acc_lo[0] ? mcand : '0;

  ripple_adder #(.W(WIDTH)) u_add (
    .a    (acc_hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // {cout,sum,acc_lo} >> 1: the carry lands in the accumulator MSB
  assign nxt_hi = {cout, sum[WIDTH-1:1]};
  assign nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= a;
            acc_hi   <= '0;
            acc_lo   <= b;
            count    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          count  <= count + 1'b1;
          if (count == LAST) begin
            product   <= {nxt_hi, nxt_lo};
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule
